servo_step_sched: RTL and testbench

Pan/tilt servo step scheduler. It takes the four raw push-buttons (Up/Down/Left/Right) and synchronises and debounces them. It then turns each press into one step, followed by timed auto-repeat while the button is held, and applies every step to saturating 6-bit duty registers Duty_X / Duty_Y. Those registers feed the servo PWM generators. The block is the sole owner of the duty values; there is no free-running combinational update.

---
 rtl/servo_step_sched_if.sv | 32 +++
 rtl/servo_step_sched.sv | 206 ++++++++++++++++++++
 tb/tb_servo_step_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/servo_step_sched_if.sv
// Button/duty bundle for the pan/tilt servo step scheduler.
//
// Signals:
//   Bt_Up, Bt_Down, Bt_Left, Bt_Right : raw asynchronous push-buttons, active-high
//   Duty_X, Duty_Y                    : registered 6-bit pan/tilt duty values
//   Step_X, Step_Y                    : one-cycle pulse when an axis step is applied
//   Limit_X, Limit_Y                  : high while the axis duty sits at a bound
//
// The master side owns the buttons and consumes the duty values.
// The slave side is the scheduler itself.
interface servo_step_sched_if;
  logic       Bt_Up;
  logic       Bt_Down;
  logic       Bt_Left;
  logic       Bt_Right;
  logic [5:0] Duty_X;
  logic [5:0] Duty_Y;
  logic       Step_X;
  logic       Step_Y;
  logic       Limit_X;
  logic       Limit_Y;

  modport master (
    output Bt_Up, Bt_Down, Bt_Left, Bt_Right,
    input  Duty_X, Duty_Y, Step_X, Step_Y, Limit_X, Limit_Y
  );

  modport slave (
    input  Bt_Up, Bt_Down, Bt_Left, Bt_Right,
    output Duty_X, Duty_Y, Step_X, Step_Y, Limit_X, Limit_Y
  );
endinterface

// File: rtl/servo_step_sched.sv
// Pan/tilt servo step scheduler.
//
// Synchronises and debounces four push-buttons.
// Each press becomes one step, followed by timed auto-repeat while the button is held.
// Steps are applied to saturating 6-bit duty registers.
//
// Ports:
//   Clk : system clock, rising edge
//   Rst : synchronous active-high reset
//   bus : servo_step_sched_if.slave
//         - buttons in
//         - Duty_X/Duty_Y, Step_X/Step_Y, Limit_X/Limit_Y out
//
// Axis index 0 is X (Left = -, Right = +).
// Axis index 1 is Y (Down = -, Up = +).
module servo_step_sched #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int STEP            = 4,
  parameter int DUTY_MIN        = 0,
  parameter int DUTY_MAX        = 60,
  parameter int DUTY_INIT       = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  servo_step_sched_if.slave bus
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]       INIT_DUTY   = 6'(DUTY_INIT);
  localparam logic             INIT_LIMIT  = (DUTY_INIT == DUTY_MIN) || (DUTY_INIT == DUTY_MAX);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  // Button bit order: [0] Up, [1] Down, [2] Left, [3] Right
  logic [3:0]       btn_raw;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q [4];
  logic [DEB_W-1:0] deb_cnt_d [4];

  logic [1:0]       plus, minus, req, hold, fire;
  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       dir_q, dir_d;
  logic [5:0]       duty_q [2];
  logic [5:0]       duty_d [2];
  logic [1:0]       step_q, step_d;
  logic [1:0]       limit_q, limit_d;

  assign btn_raw = {bus.Bt_Right, bus.Bt_Left, bus.Bt_Down, bus.Bt_Up};

  // Index 0 = X axis, index 1 = Y axis
  assign plus  = {deb_q[0], deb_q[3]};
  assign minus = {deb_q[1], deb_q[2]};

  // Both buttons of an axis pressed is a conflict, which reads as no request
  assign req = plus ^ minus;

  // Keep going only while the same single direction is still requested
  assign hold = req & ~(plus ^ dir_q);

  // Saturating step in 7 bits, so an add or subtract can never wrap
  function automatic logic [5:0] apply_step(input logic [5:0] duty, input logic up);
    logic [6:0] wide;
    wide = {1'b0, duty};
    if (up) begin
      if (wide + 7'(STEP) > 7'(DUTY_MAX)) return 6'(DUTY_MAX);
      else                                return 6'(wide + 7'(STEP));
    end else begin
      if (wide < 7'(DUTY_MIN + STEP)) return 6'(DUTY_MIN);
      else                            return 6'(wide - 7'(STEP));
    end
  endfunction

  // Two-flop synchroniser feeding a per-button debouncer.
  // A button's counter only runs while the synchronised sample disagrees with the accepted level.
  // Any agreeing sample clears that button's counter.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_d[i]     = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  // Next-state logic for both axis FSMs.
  // Any drop-out from DELAY/REPEAT goes to IDLE for one cycle before a new request is honoured.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      state_d[a] = state_q[a];
      cnt_d[a]   = cnt_q[a];
      dir_d[a]   = dir_q[a];
      case (state_q[a])
        IDLE: begin
          if (req[a]) begin
            state_d[a] = DELAY;
            cnt_d[a]   = '0;
            dir_d[a]   = plus[a];
          end
        end
        DELAY: begin
          if (!hold[a]) begin
            state_d[a] = IDLE;
            cnt_d[a]   = '0;
          end else if (cnt_q[a] == DELAY_LAST) begin
            state_d[a] = REPEAT;
            cnt_d[a]   = '0;
          end else begin
            cnt_d[a] = cnt_q[a] + 1'b1;
          end
        end
        REPEAT: begin
          if (!hold[a]) begin
            state_d[a] = IDLE;
            cnt_d[a]   = '0;
          end else if (cnt_q[a] == PERIOD_LAST) begin
            cnt_d[a] = '0;
          end else begin
            cnt_d[a] = cnt_q[a] + 1'b1;
          end
        end
        default: begin
          state_d[a] = IDLE;
          cnt_d[a]   = '0;
        end
      endcase
    end
  end

  // Output logic: decide which axes step this cycle and compute the new duty and flags.
  // A step on an IDLE exit uses the freshly requested direction.
  // Steps in DELAY/REPEAT use the latched one.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      fire[a] = 1'b0;
      case (state_q[a])
        IDLE:    fire[a] = req[a];
        DELAY:   fire[a] = hold[a] && (cnt_q[a] == DELAY_LAST);
        REPEAT:  fire[a] = hold[a] && (cnt_q[a] == PERIOD_LAST);
        default: fire[a] = 1'b0;
      endcase
      duty_d[a]  = fire[a] ? apply_step(duty_q[a], plus[a]) : duty_q[a];
      step_d[a]  = fire[a];
      limit_d[a] = (duty_d[a] == 6'(DUTY_MIN)) || (duty_d[a] == 6'(DUTY_MAX));
    end
  end

  // State register for the synchronisers, debouncers, FSMs and duty outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      for (int a = 0; a < 2; a++) begin
        state_q[a] <= IDLE;
        cnt_q[a]   <= '0;
        duty_q[a]  <= INIT_DUTY;
      end
      dir_q   <= '0;
      step_q  <= '0;
      limit_q <= {INIT_LIMIT, INIT_LIMIT};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      for (int a = 0; a < 2; a++) begin
        state_q[a] <= state_d[a];
        cnt_q[a]   <= cnt_d[a];
        duty_q[a]  <= duty_d[a];
      end
      dir_q   <= dir_d;
      step_q  <= step_d;
      limit_q <= limit_d;
    end
  end

  assign bus.Duty_X  = duty_q[0];
  assign bus.Duty_Y  = duty_q[1];
  assign bus.Step_X  = step_q[0];
  assign bus.Step_Y  = step_q[1];
  assign bus.Limit_X = limit_q[0];
  assign bus.Limit_Y = limit_q[1];

endmodule

// File: tb/tb_servo_step_sched.sv
// Directed testbench for servo_step_sched with short timing parameters.
// Every check runs one cycle-accurate comparison against hand-derived values.
// Edge 0 is the first rising edge that samples a newly driven button level.
module tb_servo_step_sched;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   pulses;
  int   n;
  int   exp_duty;
  logic exp_step;

  servo_step_sched_if bus ();

  servo_step_sched #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .STEP           (4),
    .DUTY_MIN       (0),
    .DUTY_MAX       (60),
    .DUTY_INIT      (32)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Advance one rising edge, then settle so outputs reflect that edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic up, input logic down, input logic left, input logic right);
    bus.Bt_Up    = up;
    bus.Bt_Down  = down;
    bus.Bt_Left  = left;
    bus.Bt_Right = right;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyReset();
    applyStimulus(0, 0, 0, 0);
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    // Reset and idle behaviour
    applyReset();
    checkOutput("rst_duty_x", bus.Duty_X, 32);
    checkOutput("rst_duty_y", bus.Duty_Y, 32);
    checkOutput("rst_step_x", bus.Step_X, 0);
    checkOutput("rst_step_y", bus.Step_Y, 0);
    checkOutput("rst_limit_x", bus.Limit_X, 0);
    checkOutput("rst_limit_y", bus.Limit_Y, 0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      pulses += int'(bus.Step_X) + int'(bus.Step_Y);
    end
    checkOutput("idle_duty_x", bus.Duty_X, 32);
    checkOutput("idle_duty_y", bus.Duty_Y, 32);
    checkOutput("idle_pulses", pulses, 0);
    checkOutput("idle_limit_x", bus.Limit_X, 0);
    checkOutput("idle_limit_y", bus.Limit_Y, 0);

    // Up held for edges 0..43: steps at edges 6, 26, 34, 42
    applyReset();
    applyStimulus(1, 0, 0, 0);
    pulses = 0;
    for (int e = 0; e < 60; e++) begin
      tick();
      if (e == 43) applyStimulus(0, 0, 0, 0);
      n = int'(e >= 6) + int'(e >= 26) + int'(e >= 34) + int'(e >= 42);
      exp_step = (e == 6) || (e == 26) || (e == 34) || (e == 42);
      pulses += int'(bus.Step_Y);
      checkOutput("up_duty_y", bus.Duty_Y, 32 + 4 * n);
      checkOutput("up_step_y", bus.Step_Y, exp_step);
    end
    checkOutput("up_pulses", pulses, 4);
    checkOutput("up_duty_x", bus.Duty_X, 32);

    // Right glitches of 3 cycles at 5-cycle spacing never pass the debouncer
    applyReset();
    pulses = 0;
    for (int g = 0; g < 10; g++) begin
      applyStimulus(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
        tick();
        pulses += int'(bus.Step_X);
      end
      applyStimulus(0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
        tick();
        pulses += int'(bus.Step_X);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(bus.Step_X);
    end
    checkOutput("glitch_pulses", pulses, 0);
    checkOutput("glitch_duty_x", bus.Duty_X, 32);

    // Up and Down together: conflict, then Down release gives one step 6 edges later
    applyReset();
    applyStimulus(1, 1, 0, 0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      pulses += int'(bus.Step_Y);
    end
    checkOutput("conflict_pulses", pulses, 0);
    checkOutput("conflict_duty_y", bus.Duty_Y, 32);
    applyStimulus(1, 0, 0, 0);
    for (int e = 0; e < 10; e++) begin
      tick();
      checkOutput("unconflict_duty_y", bus.Duty_Y, (e >= 6) ? 36 : 32);
      checkOutput("unconflict_step_y", bus.Step_Y, e == 6);
    end

    // Left and Up on the same edge step both axes on the same edge
    applyReset();
    applyStimulus(1, 0, 1, 0);
    for (int e = 0; e < 10; e++) begin
      tick();
      checkOutput("both_duty_x", bus.Duty_X, (e >= 6) ? 28 : 32);
      checkOutput("both_duty_y", bus.Duty_Y, (e >= 6) ? 36 : 32);
      checkOutput("both_step_x", bus.Step_X, e == 6);
      checkOutput("both_step_y", bus.Step_Y, e == 6);
    end

    // Right held into saturation at 60, with steps still pulsing there
    applyReset();
    applyStimulus(0, 0, 0, 1);
    n = 0;
    for (int e = 0; e < 80; e++) begin
      tick();
      exp_step = (e == 6) || ((e >= 26) && ((e - 26) % 8 == 0));
      if (exp_step) n++;
      exp_duty = (32 + 4 * n > 60) ? 60 : 32 + 4 * n;
      checkOutput("sat_duty_x", bus.Duty_X, exp_duty);
      checkOutput("sat_step_x", bus.Step_X, exp_step);
      checkOutput("sat_limit_x", bus.Limit_X, exp_duty == 60);
    end

    // Reset mid-hold, then a fresh press from the still-held button
    Rst = 1'b1;
    tick();
    checkOutput("midrst_duty_x", bus.Duty_X, 32);
    checkOutput("midrst_limit_x", bus.Limit_X, 0);
    checkOutput("midrst_step_x", bus.Step_X, 0);
    Rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      checkOutput("rehold_duty_x", bus.Duty_X, (e >= 6) ? 36 : 32);
      checkOutput("rehold_step_x", bus.Step_X, e == 6);
    end
    applyStimulus(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
